fetch_unit: RTL and testbench

Instruction fetch stage of the multi-cycle schoolRISCV core and the consuming end of the writeback stage's next-PC output. It holds the architectural PC, fetches one instruction word through a req/ack instruction-memory handshake, and presents it to decode with a valid/ready handshake. It then waits for writeback to publish the resolved next PC (branch target or PC+4) before fetching again.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    function automatic logic pc_aligned(input logic [31:0] pc);
        return (pc[1:0] & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem req/ack, decode valid/ready, writeback next-PC strobe, status.
// master = fetch unit, slave = memory/decode/writeback environment.
interface fetch_unit_if;
    logic [31:0] newPC_i;
    logic        newPCValid_i;
    logic        imemReq_o;
    logic [31:0] imemAddr_o;
    logic        imemAck_i;
    logic [31:0] imemData_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pcPlus4_o;
    logic        instrValid_o;
    logic        instrReady_i;
    logic [31:0] instrCount_o;
    logic        fault_o;

    modport master (
        input  newPC_i, newPCValid_i, imemAck_i, imemData_i, instrReady_i,
        output imemReq_o, imemAddr_o, instr_o, pc_o, pcPlus4_o,
               instrValid_o, instrCount_o, fault_o
    );

    modport slave (
        output newPC_i, newPCValid_i, imemAck_i, imemData_i, instrReady_i,
        input  imemReq_o, imemAddr_o, instr_o, pc_o, pcPlus4_o,
               instrValid_o, instrCount_o, fault_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch for the multi-cycle core: holds PC, fetches one word, hands it to decode.
// Latency: FETCH>=1, ISSUE>=1, WAIT>=1 cycles per instruction; outputs decoded from state flops.
// Backpressure: stalls in FETCH until imemAck_i and in ISSUE until instrReady_i; no timeouts.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic        fault_q, fault_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (bus.imemAck_i) state_d = ISSUE;
            ISSUE: if (bus.instrReady_i) state_d = WAIT;
            WAIT: begin
                if (bus.newPCValid_i) begin
                    state_d = pc_aligned(bus.newPC_i) ? FETCH : HALT;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            count_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    // A misaligned redirect leaves the PC pointing at the last good instruction.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        fault_d = fault_q;
        case (state_q)
            FETCH: if (bus.imemAck_i) instr_d = bus.imemData_i;
            ISSUE: if (bus.instrReady_i) count_d = count_q + 32'd1;
            WAIT: begin
                if (bus.newPCValid_i) begin
                    if (pc_aligned(bus.newPC_i)) begin
                        pc_d = bus.newPC_i;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.imemReq_o    = (state_q == FETCH);
    assign bus.instrValid_o = (state_q == ISSUE);
    assign bus.imemAddr_o   = pc_q;
    assign bus.pc_o         = pc_q;
    assign bus.pcPlus4_o    = pc_q + PC_STEP;
    assign bus.instr_o      = instr_q;
    assign bus.instrCount_o = count_q;
    assign bus.fault_o      = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: per-cycle input/expected-output table plus reset sequences.
module tb_fetch_unit;

    logic clk;
    logic rst_n;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] data;
        logic        rdy;
        logic        npv;
        logic [31:0] npc;
        logic        e_req;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_cnt;
        logic        e_fault;
    } vec_t;

    int n_vec;
    int n_bad;
    vec_t vecs [21];

    task automatic drive(input vec_t v);
        bus.imemAck_i    = v.ack;
        bus.imemData_i   = v.data;
        bus.instrReady_i = v.rdy;
        bus.newPCValid_i = v.npv;
        bus.newPC_i      = v.npc;
    endtask

    task automatic check(input vec_t v, input string name);
        n_vec++;
        if (bus.imemReq_o !== v.e_req || bus.instrValid_o !== v.e_vld ||
            bus.instr_o !== v.e_instr || bus.pc_o !== v.e_pc ||
            bus.imemAddr_o !== v.e_pc || bus.pcPlus4_o !== v.e_pc4 ||
            bus.instrCount_o !== v.e_cnt || bus.fault_o !== v.e_fault) begin
            n_bad++;
            $display("FAIL %s: got req=%b vld=%b instr=%h pc=%h addr=%h pc4=%h cnt=%0d fault=%b; want req=%b vld=%b instr=%h pc=%h pc4=%h cnt=%0d fault=%b",
                     name, bus.imemReq_o, bus.instrValid_o, bus.instr_o, bus.pc_o,
                     bus.imemAddr_o, bus.pcPlus4_o, bus.instrCount_o, bus.fault_o,
                     v.e_req, v.e_vld, v.e_instr, v.e_pc, v.e_pc4, v.e_cnt, v.e_fault);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        drive(v);
        @(posedge clk);
        #1;
        check(v, name);
    endtask

    localparam vec_t IDLE_IN = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
                                 1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 32'd0, 1'b0};

    initial begin
        n_vec = 0;
        n_bad = 0;

        //            ack   data           rdy   npv   npc            req   vld   instr          pc             pc4            cnt    fault
        vecs[0]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         32'h4,         32'd0, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h13,        32'h0,         32'h4,         32'd0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h13,        32'h0,         32'h4,         32'd1, 1'b0};
        vecs[3]  = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h13,        32'h0,         32'h4,         32'd1, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h100,       1'b1, 1'b0, 32'h13,        32'h100,       32'h104,       32'd1, 1'b0};
        for (int i = 5; i <= 9; i++)
            vecs[i] = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h13,        32'h100,       32'h104,       32'd1, 1'b0};
        vecs[10] = '{1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0050_0093, 32'h100,       32'h104,       32'd1, 1'b0};
        vecs[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0050_0093, 32'h100,       32'h104,       32'd1, 1'b0};
        vecs[12] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h40,        1'b0, 1'b1, 32'h0050_0093, 32'h100,       32'h104,       32'd1, 1'b0};
        vecs[13] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0050_0093, 32'h100,       32'h104,       32'd1, 1'b0};
        vecs[14] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        1'b0, 1'b0, 32'h0050_0093, 32'h100,       32'h104,       32'd2, 1'b0};
        vecs[15] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0050_0093, 32'hFFFF_FFFC, 32'h0,         32'd2, 1'b0};
        vecs[16] = '{1'b1, 32'h0000_0073, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h73,        32'hFFFF_FFFC, 32'h0,         32'd2, 1'b0};
        vecs[17] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h73,        32'hFFFF_FFFC, 32'h0,         32'd3, 1'b0};
        vecs[18] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h102,       1'b0, 1'b0, 32'h73,        32'hFFFF_FFFC, 32'h0,         32'd3, 1'b1};
        vecs[19] = '{1'b1, 32'h0000_0013, 1'b1, 1'b1, 32'h200,       1'b0, 1'b0, 32'h73,        32'hFFFF_FFFC, 32'h0,         32'd3, 1'b1};
        vecs[20] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h100,       1'b0, 1'b0, 32'h73,        32'hFFFF_FFFC, 32'h0,         32'd3, 1'b1};

        // Reset state
        rst_n = 1'b0;
        drive(IDLE_IN);
        repeat (2) @(posedge clk);
        #1;
        check(IDLE_IN, "reset_state");
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset out of HALT, checked before any clock edge
        drive(IDLE_IN);
        #1;
        rst_n = 1'b0;
        #1;
        check(IDLE_IN, "async_reset_from_halt");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset during FETCH; an ack on the first cycle after release must be ignored
        apply('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h4, 32'd0, 1'b0}, "refetch_start");
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply('{1'b1, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h4, 32'd0, 1'b0}, "late_ack_ignored");
        apply('{1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h4, 32'd0, 1'b0}, "fetch_after_reset");
        apply('{1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13, 32'h0, 32'h4, 32'd0, 1'b0}, "ack_after_reset");
        apply('{1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h13, 32'h0, 32'h4, 32'd1, 1'b0}, "issue_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
